uart_word_tx: RTL
=================

# uart_word_tx

Serialises a multi-byte word onto a UART line, 8N1, least-significant byte first, using a valid/ready handshake on the parallel side. It is the transmit-direction counterpart of the board's UART debug receive path. It streams datapath results, such as divider quotient/remainder words, from the 100 MHz fabric clock out of `uart_txd` to the host.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868. Clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `BYTES`, default 4. Number of bytes per word. Must be ≥ 1.

Ports:
- `clk_in`, input, 1. Single system clock.
- `rst_n_in`, input, 1. Reset; asynchronous, active-low.
- `data_in`, input, 8*BYTES. Word to transmit. Sampled only on an accepting handshake.
- `data_valid_in`, input, 1. Word is offered.
- `ready_out`, output, 1. Block is idle and can accept a word.
- `tx_out`, output, 1. UART serial line. Idle level is high.
- `busy_out`, output, 1. High while a word is being shifted out; equals !ready_out.
- `done_out`, output, 1. One-cycle pulse after the final stop bit of a word completes.

## Operation

- States: `IDLE`, `START`, `DATA`, `STOP`.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1.
  - Bit index runs 0..7.
  - Byte index runs 0..BYTES-1.
- In `IDLE`:
  - `ready_out` = 1 and `tx_out` = 1.
  - An accept occurs on any rising edge where `data_valid_in` && `ready_out`. On accept, latch `data_in` into the shift register, clear the counters, and go to `START`.
- `START`:
  - `tx_out` = 0 for CLKS_PER_BIT cycles, then go to `DATA`.
- `DATA`:
  - `tx_out` = current byte bit[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles.
  - After bit 7, go to `STOP`.
- `STOP`:
  - `tx_out` = 1 for CLKS_PER_BIT cycles.
  - Then, if byte index < BYTES-1: increment byte index and go to `START`. There is no idle gap between bytes.
  - Otherwise go to `IDLE` and assert `done_out`.
- Byte order: byte 0 = `data_in[7:0]` is sent first; byte BYTES-1 is sent last.
- `data_in` and `data_valid_in` are ignored while busy. There is no queueing.
- `tx_out`, `done_out` and the state are registered.
- `ready_out` and `busy_out` decode the registered state.

## Timing

- Reset values, forced asynchronously while `rst_n_in` = 0:
  - `tx_out` = 1, `ready_out` = 1, `busy_out` = 0, `done_out` = 0.
  - State = `IDLE`; all counters = 0.
- Latency, with the accept at edge 0:
  - `ready_out` falls after edge 0.
  - `tx_out` falls at edge 0 and stays low through edge CLKS_PER_BIT.
- Duration:
  - Each byte occupies exactly 10*CLKS_PER_BIT cycles.
  - A word occupies 10*BYTES*CLKS_PER_BIT cycles, on edges 1..10*BYTES*CLKS_PER_BIT.
- Completion:
  - On the first cycle back in `IDLE`, `done_out` = 1 for exactly one cycle and `ready_out` = 1.
- Back-to-back words:
  - If `data_valid_in` = 1 during the `done_out` cycle, that word is accepted immediately.
  - Its start bit directly follows the previous stop bit, with no extra idle cycles.
- Reset mid-frame:
  - `tx_out` returns to 1 immediately and the latched word is discarded.
  - No `done_out` pulse is produced.
  - After `rst_n_in` rises, the block is in `IDLE` with `ready_out` = 1.
- Out-of-range parameters (`CLKS_PER_BIT` < 2 or `BYTES` < 1) are rejected by an elaboration-time assertion.

## Test plan

Scenarios 1–4 and 6 use CLKS_PER_BIT=4 and BYTES=4.

1. Reset check: hold `rst_n_in`=0 and toggle inputs. Required: `tx_out`=1, `ready_out`=1, `busy_out`=0 and `done_out`=0 throughout. After release, `ready_out`=1 and `tx_out`=1 are unchanged.
2. Single word 0x12345678, accepted at edge 0. Required:
   - A UART decoder sees bytes 0x78, 0x56, 0x34, 0x12, each with a start bit of 0 and a stop bit of 1.
   - `tx_out` is low on edges 1–4.
   - `busy_out` is high on edges 1–160.
   - `done_out` pulses only on the cycle after edge 160.
3. Back-to-back: words 0xA5A5A5A5 and 0x0000FFFF, with the second presented during the `done_out` cycle. Required: 8 contiguous frames of 40 cycles per word with no idle gap, and two `done_out` pulses exactly 160 cycles apart.
4. Ignore while busy: change `data_in` to 0xDEADBEEF and pulse `data_valid_in` mid-frame. Required: the original word is sent unaltered, with exactly one `done_out` pulse.
5. Reset mid-frame: with CLKS_PER_BIT=868, assert `rst_n_in`=0 during byte 2. Required:
   - `tx_out`=1 asynchronously, with no `done_out`.
   - After release, a new word 0x000000C3 is transmitted correctly.
6. Edge data: with BYTES=1, send 0x00 then 0xFF. Required:
   - For 0x00, the line is low for 9*CLKS_PER_BIT cycles (start bit plus eight 0 data bits), then high for the stop bit.
   - For 0xFF, the line is low only for the start bit.
   - Each word has a total duration of 40 cycles.

Source files
------------

// File: rtl/uart_word_tx.sv
// UART 8N1 word transmitter: sends BYTES bytes LSB-byte first over tx_out.
// Parallel side uses a valid/ready handshake; done_out pulses once per word.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BYTES        = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [8*BYTES-1:0] data_in,
    input  logic               data_valid_in,
    output logic               ready_out,
    output logic               tx_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int CW = $clog2(CLKS_PER_BIT < 2 ? 2 : CLKS_PER_BIT);
    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

    if (CLKS_PER_BIT < 2 || BYTES < 1) begin : g_param_check
        $error("uart_word_tx: CLKS_PER_BIT must be >= 2 and BYTES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [BW-1:0]      byte_q, byte_d;
    logic [8*BYTES-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx is registered, so each branch loads the level of the next bit
    // on the same edge that enters that bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (data_valid_in) begin
                    shift_d = data_in;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready_out = (state_q == IDLE);
    assign busy_out  = !ready_out;
    assign tx_out    = tx_q;
    assign done_out  = done_q;

endmodule
